// File: rtl/mem_stage.sv
// Memory-access stage: byte-addressed synchronous-read data memory with RV32
// load/store sizing, a one-cycle load stall, and access-fault detection.
module mem_stage #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_WORDS = 1024,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS),
    parameter int ADDR_SIZE = $clog2(NUM_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [ADDR_SIZE-1:0] pc,
    input  logic [WORD_SIZE-1:0] alu_result,
    input  logic [WORD_SIZE-1:0] store_data,
    input  logic [2:0]           funct3,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [REG_SEL-1:0]   rd,
    input  logic                 mem_to_reg,
    input  logic                 jump,
    input  logic                 reg_write,
    output logic [ADDR_SIZE-1:0] pc_out,
    output logic [WORD_SIZE-1:0] result_out,
    output logic [REG_SEL-1:0]   rd_out,
    output logic                 mem_to_reg_out,
    output logic                 jump_out,
    output logic                 reg_write_out,
    output logic [WORD_SIZE-1:0] read_data,
    output logic                 stall_out,
    output logic                 fault_out
);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t              state;
    logic [2:0]          f3_q;
    logic [1:0]          off_q;
    logic [3:0][7:0]     mem [NUM_WORDS];
    logic [WORD_SIZE-1:0] ram_q;

    logic [ADDR_SIZE-1:0] idx;
    logic [1:0]           off;
    logic                 legal_load, legal_store, misaligned, bad;
    logic                 load_go, store_go;
    logic [3:0][7:0]      wdata;
    logic [3:0]           be;
    logic [7:0]           sel_byte;
    logic [15:0]          sel_half;

    assign idx = alu_result[ADDR_SIZE+1:2];
    assign off = alu_result[1:0];

    assign pc_out         = pc;
    assign result_out     = alu_result;
    assign rd_out         = rd;
    assign mem_to_reg_out = mem_to_reg;
    assign jump_out       = jump;
    assign reg_write_out  = reg_write & ~fault_out;

    // Fault checking only applies to a new access presented in IDLE.
    always_comb begin
        legal_load  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);
        legal_store = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        misaligned  = ((funct3[1:0] == 2'b01) && off[0]) ||
                      ((funct3[1:0] == 2'b10) && (off != 2'b00));
        bad         = (mem_read && mem_write) || (mem_read && !legal_load) ||
                      (mem_write && !legal_store) || misaligned;
        fault_out   = (state == IDLE) && !flush && (mem_read || mem_write) && bad;
        load_go     = (state == IDLE) && !flush && mem_read && !fault_out;
        store_go    = (state == IDLE) && !flush && mem_write && !fault_out;
        stall_out   = load_go;
    end

    // Store data is replicated across lanes so only the byte enables select placement.
    always_comb begin
        wdata = store_data;
        be    = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata = {4{store_data[7:0]}};
                be    = 4'b0001 << off;
            end
            2'b01: begin
                wdata = {2{store_data[15:0]}};
                be    = off[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // NOTE: the memory array and its read register carry no reset; clearing a RAM
    // is not possible in one cycle, and rst only gates the write enable.
    always_ff @(posedge clk) begin
        if (!rst && store_go) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][i] <= wdata[i];
            end
        end
        if (load_go) ram_q <= mem[idx];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            f3_q  <= 3'b000;
            off_q <= 2'b00;
        end else begin
            case (state)
                IDLE: if (load_go) begin
                    state <= LOAD_WAIT;
                    f3_q  <= funct3;
                    off_q <= off;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: read_data gets a default first so no path through the case infers a latch.
    always_comb begin
        read_data = '0;
        sel_byte  = ram_q[8*off_q +: 8];
        sel_half  = off_q[1] ? ram_q[31:16] : ram_q[15:0];
        if (state == LOAD_WAIT && !flush) begin
            case (f3_q)
                3'b000:  read_data = {{24{sel_byte[7]}}, sel_byte};
                3'b001:  read_data = {{16{sel_half[15]}}, sel_half};
                3'b100:  read_data = {24'd0, sel_byte};
                3'b101:  read_data = {16'd0, sel_half};
                default: read_data = ram_q;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of loads/stores plus hand
// sequences for flush and reset during a pending load.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [9:0]  pc;
    logic [31:0] alu_result, store_data;
    logic [2:0]  funct3;
    logic        mem_read, mem_write;
    logic [4:0]  rd;
    logic        mem_to_reg, jump, reg_write;
    logic [9:0]  pc_out;
    logic [31:0] result_out;
    logic [4:0]  rd_out;
    logic        mem_to_reg_out, jump_out, reg_write_out;
    logic [31:0] read_data;
    logic        stall_out, fault_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .pc(pc), .alu_result(alu_result),
        .store_data(store_data), .funct3(funct3), .mem_read(mem_read),
        .mem_write(mem_write), .rd(rd), .mem_to_reg(mem_to_reg), .jump(jump),
        .reg_write(reg_write), .pc_out(pc_out), .result_out(result_out),
        .rd_out(rd_out), .mem_to_reg_out(mem_to_reg_out), .jump_out(jump_out),
        .reg_write_out(reg_write_out), .read_data(read_data),
        .stall_out(stall_out), .fault_out(fault_out)
    );

    typedef struct {
        string       name;
        logic        rd_en, wr_en, fl;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        logic        exp_stall, exp_fault;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        flush = 0; mem_read = 0; mem_write = 0; funct3 = 3'b000;
        alu_result = 32'h0; store_data = 32'h0; reg_write = 0;
        pc = '0; rd = '0; mem_to_reg = 0; jump = 0;
    endtask

    task automatic drive(input logic r, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic fl);
        mem_read = r; mem_write = w; funct3 = f3; alu_result = a;
        store_data = d; flush = fl; reg_write = 1;
    endtask

    task automatic add(input string n, input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic fl,
                       input logic es, input logic ef, input logic [31:0] ed);
        vec_t v;
        v.name = n; v.rd_en = r; v.wr_en = w; v.f3 = f3; v.addr = a; v.wdata = d;
        v.fl = fl; v.exp_stall = es; v.exp_fault = ef; v.exp_data = ed;
        vecs.push_back(v);
    endtask

    // One access in IDLE; for loads the held inputs span the LOAD_WAIT cycle too.
    task automatic do_op(input vec_t v);
        drive(v.rd_en, v.wr_en, v.f3, v.addr, v.wdata, v.fl);
        @(negedge clk);
        check({v.name, " stall"}, {31'd0, stall_out}, {31'd0, v.exp_stall});
        check({v.name, " fault"}, {31'd0, fault_out}, {31'd0, v.exp_fault});
        check({v.name, " reg_write_out"}, {31'd0, reg_write_out}, {31'd0, !v.exp_fault});
        check({v.name, " idle read_data"}, read_data, 32'h0);
        @(posedge clk); #1;
        if (v.exp_stall) begin
            @(negedge clk);
            check({v.name, " wait stall"}, {31'd0, stall_out}, 32'd0);
            check({v.name, " wait fault"}, {31'd0, fault_out}, 32'd0);
            check({v.name, " read_data"}, read_data, v.exp_data);
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset stall", {31'd0, stall_out}, 32'd0);
        check("reset read_data", read_data, 32'h0);
        check("reset fault", {31'd0, fault_out}, 32'd0);

        // Passthroughs with no access presented.
        pc = 10'h155; rd = 5'h1A; mem_to_reg = 1; jump = 1; reg_write = 1;
        alu_result = 32'h1234_5678;
        @(negedge clk);
        check("pc_out", {22'd0, pc_out}, 32'h155);
        check("rd_out", {27'd0, rd_out}, 32'h1A);
        check("result_out", result_out, 32'h1234_5678);
        check("ctl_out", {29'd0, mem_to_reg_out, jump_out, reg_write_out}, 32'h7);
        @(posedge clk); #1;
        idle_inputs();

        //   name          r  w  f3      addr          wdata         fl st ft data
        add("sw_20",      0, 1, 3'b010, 32'h20,       32'h0000_0000, 0, 0, 0, 32'h0);
        add("sw_10",      0, 1, 3'b010, 32'h10,       32'hDEAD_BEEF, 0, 0, 0, 32'h0);
        add("lw_10",      1, 0, 3'b010, 32'h10,       32'h0,         0, 1, 0, 32'hDEAD_BEEF);
        add("sb_13",      0, 1, 3'b000, 32'h13,       32'h1234_5680, 0, 0, 0, 32'h0);
        add("lb_13",      1, 0, 3'b000, 32'h13,       32'h0,         0, 1, 0, 32'hFFFF_FF80);
        add("lbu_13",     1, 0, 3'b100, 32'h13,       32'h0,         0, 1, 0, 32'h0000_0080);
        add("lw_10b",     1, 0, 3'b010, 32'h10,       32'h0,         0, 1, 0, 32'h80AD_BEEF);
        add("lb_11",      1, 0, 3'b000, 32'h11,       32'h0,         0, 1, 0, 32'hFFFF_FFBE);
        add("sh_22",      0, 1, 3'b001, 32'h22,       32'hABCD_1234, 0, 0, 0, 32'h0);
        add("lh_22",      1, 0, 3'b001, 32'h22,       32'h0,         0, 1, 0, 32'h0000_1234);
        add("lh_21",      1, 0, 3'b001, 32'h21,       32'h0,         0, 0, 1, 32'h0);
        add("sh_21",      0, 1, 3'b001, 32'h21,       32'h0000_FFFF, 0, 0, 1, 32'h0);
        add("lw_20",      1, 0, 3'b010, 32'h20,       32'h0,         0, 1, 0, 32'h1234_0000);
        add("lb_22",      1, 0, 3'b000, 32'h22,       32'h0,         0, 1, 0, 32'h0000_0034);
        add("sh_26",      0, 1, 3'b001, 32'h26,       32'h5555_8001, 0, 0, 0, 32'h0);
        add("lh_26",      1, 0, 3'b001, 32'h26,       32'h0,         0, 1, 0, 32'hFFFF_8001);
        add("lhu_26",     1, 0, 3'b101, 32'h26,       32'h0,         0, 1, 0, 32'h0000_8001);
        add("sw_wrap",    0, 1, 3'b010, 32'h1000,     32'hCAFE_F00D, 0, 0, 0, 32'h0);
        add("lw_0",       1, 0, 3'b010, 32'h0,        32'h0,         0, 1, 0, 32'hCAFE_F00D);
        add("rw_both",    1, 1, 3'b010, 32'h0,        32'h1111_1111, 0, 0, 1, 32'h0);
        add("ld_ill",     1, 0, 3'b011, 32'h0,        32'h0,         0, 0, 1, 32'h0);
        add("st_ill",     0, 1, 3'b100, 32'h0,        32'h3333_3333, 0, 0, 1, 32'h0);
        add("sw_mis",     0, 1, 3'b010, 32'h2,        32'h4444_4444, 0, 0, 1, 32'h0);
        add("lw_mis",     1, 0, 3'b010, 32'h3,        32'h0,         0, 0, 1, 32'h0);
        add("sw_flush",   0, 1, 3'b010, 32'h0,        32'h2222_2222, 1, 0, 0, 32'h0);
        add("lh21_flush", 1, 0, 3'b001, 32'h21,       32'h0,         1, 0, 0, 32'h0);
        add("lw_flush",   1, 0, 3'b010, 32'h0,        32'h0,         1, 0, 0, 32'h0);
        add("lw_0b",      1, 0, 3'b010, 32'h0,        32'h0,         0, 1, 0, 32'hCAFE_F00D);

        foreach (vecs[i]) do_op(vecs[i]);

        // Flush during LOAD_WAIT: data suppressed, FSM back to IDLE.
        drive(1, 0, 3'b010, 32'h10, 32'h0, 0);
        @(negedge clk);
        check("flw stall", {31'd0, stall_out}, 32'd1);
        @(posedge clk); #1;
        flush = 1;
        @(negedge clk);
        check("flw read_data", read_data, 32'h0);
        check("flw wait stall", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #1;
        flush = 0;
        @(negedge clk);
        check("flw idle again", {31'd0, stall_out}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("flw reload", read_data, 32'h80AD_BEEF);
        @(posedge clk); #1;
        idle_inputs();

        // Reset during LOAD_WAIT aborts the load.
        drive(1, 0, 3'b010, 32'h10, 32'h0, 0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        idle_inputs();
        @(negedge clk);
        check("rlw stall", {31'd0, stall_out}, 32'd0);
        check("rlw read_data", read_data, 32'h0);
        check("rlw fault", {31'd0, fault_out}, 32'd0);
        @(posedge clk); #1;

        // A store presented while rst is high must not write.
        rst = 1;
        drive(0, 1, 3'b010, 32'h10, 32'h5555_5555, 0);
        @(posedge clk); #1;
        rst = 0;
        idle_inputs();
        begin
            vec_t v;
            v.name = "lw_after_rst_store"; v.rd_en = 1; v.wr_en = 0; v.f3 = 3'b010;
            v.addr = 32'h10; v.wdata = 32'h0; v.fl = 0; v.exp_stall = 1;
            v.exp_fault = 0; v.exp_data = 32'h80AD_BEEF;
            do_op(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
